// File: rtl/lfsr_matvec.sv
// GF(2) matrix-vector multiplier: computes A*x one output bit per clock.
// The rows of A come from a Galois LFSR that starts at SEED, so A is never stored.
module lfsr_matvec #(
  parameter int             M    = 256,
  parameter int             N    = 128,
  parameter logic [N-1:0]   POLY = 'h87,
  parameter logic [N-1:0]   SEED = 'h1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  x_in,
  output logic [M-1:0]  mlt_out,
  input  logic          req_valid,
  output logic          req_ready,
  output logic          req_busy,
  output logic          res_valid,
  input  logic          res_ready
);

  localparam int CW = (M > 1) ? $clog2(M) : 1;
  localparam logic [CW-1:0] LAST = CW'(M - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [N-1:0]   row;
  logic [N-1:0]   x_lat;
  logic [N-1:0]   row_next;
  logic           row_par;

  always_comb begin
    row_next = {row[N-2:0], 1'b0} ^ (row[N-1] ? POLY : '0);
    row_par  = ^(row & x_lat);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      row       <= SEED;
      x_lat     <= '0;
      mlt_out   <= '0;
      req_ready <= 1'b1;
      req_busy  <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            x_lat     <= x_in;
            row       <= SEED;
            cnt       <= '0;
            mlt_out   <= '0;
            req_ready <= 1'b0;
            req_busy  <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          mlt_out[cnt] <= row_par;
          row          <= row_next;
          cnt          <= cnt + 1'b1;
          // The final bit lands on this same edge, so the result is complete in DONE.
          if (cnt == LAST) begin
            req_busy  <= 1'b0;
            res_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_matvec.sv
// Bench for lfsr_matvec: a small instance (M=6, N=4) plus a default-size instance,
// checked against a software model through a result scoreboard.
module tb_lfsr_matvec;

  logic         clk = 1'b0;
  logic         rst;

  logic [3:0]   s_x;
  logic [5:0]   s_mlt;
  logic         s_rv, s_ready, s_busy, s_resv, s_rr;

  logic [127:0] l_x;
  logic [255:0] l_mlt;
  logic         l_rv, l_ready, l_busy, l_resv, l_rr;

  int checks = 0;
  int errors = 0;

  logic [255:0] sb_s[$];
  logic [255:0] sb_l[$];

  always #5 clk = ~clk;

  lfsr_matvec #(.M(6), .N(4), .POLY(4'h3), .SEED(4'h1)) dut_s (
    .clk(clk), .rst(rst), .x_in(s_x), .mlt_out(s_mlt),
    .req_valid(s_rv), .req_ready(s_ready), .req_busy(s_busy),
    .res_valid(s_resv), .res_ready(s_rr)
  );

  lfsr_matvec dut_l (
    .clk(clk), .rst(rst), .x_in(l_x), .mlt_out(l_mlt),
    .req_valid(l_rv), .req_ready(l_ready), .req_busy(l_busy),
    .res_valid(l_resv), .res_ready(l_rr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Independent reference: walk the LFSR rows and take parity against x.
  function automatic logic [255:0] model(input int m, input int n, input logic [127:0] poly,
                                         input logic [127:0] seed, input logic [127:0] x);
    logic [127:0] mask;
    logic [127:0] r;
    logic [255:0] res;
    logic         msb;
    mask = (n == 128) ? '1 : ((128'd1 << n) - 128'd1);
    r    = seed & mask;
    res  = '0;
    for (int i = 0; i < m; i++) begin
      res[i] = ^(r & x & mask);
      msb    = r[n-1];
      r      = (r << 1) & mask;
      if (msb) r = r ^ (poly & mask);
    end
    return res;
  endfunction

  task automatic accept_s(input logic [3:0] x, input string tag);
    chk({tag, "_ready_pre"}, s_ready, 1'b1);
    s_x  = x;
    s_rv = 1'b1;
    sb_s.push_back(model(6, 4, 128'h3, 128'h1, {124'b0, x}));
    tick();
    s_rv = 1'b0;
    chk({tag, "_ready_post"}, s_ready, 1'b0);
    chk({tag, "_busy_post"}, s_busy, 1'b1);
  endtask

  // Called right after the acceptance edge; bounded wait for res_valid.
  task automatic finish_req(input bit big, input bit toggle, input string tag,
                            output logic [255:0] got);
    int lat = 0;
    int bn  = 0;
    int m;
    logic [255:0] exp;
    m = big ? 256 : 6;
    while (!(big ? l_resv : s_resv) && lat < 400) begin
      if (big ? l_busy : s_busy) bn++;
      if (toggle) s_x = 4'($urandom);
      tick();
      lat++;
    end
    chk({tag, "_latency"}, lat, m);
    chk({tag, "_busy_cycles"}, bn, m);
    chk({tag, "_res_valid"}, big ? l_resv : s_resv, 1'b1);
    chk({tag, "_busy_done"}, big ? l_busy : s_busy, 1'b0);
    if (big) exp = sb_l.pop_front();
    else     exp = sb_s.pop_front();
    got = big ? l_mlt : {250'b0, s_mlt};
    chk({tag, "_result"}, got, exp);
  endtask

  task automatic release_s(input string tag, input logic [5:0] held);
    s_rr = 1'b1;
    tick();
    s_rr = 1'b0;
    chk({tag, "_rel_resv"}, s_resv, 1'b0);
    chk({tag, "_rel_ready"}, s_ready, 1'b1);
    tick();
    chk({tag, "_idle_hold"}, s_mlt, held);
  endtask

  initial begin
    logic [255:0] got;
    logic [127:0] lx;

    rst = 1'b1;
    s_x = '0; s_rv = 1'b0; s_rr = 1'b0;
    l_x = '0; l_rv = 1'b0; l_rr = 1'b0;
    tick();
    tick();
    chk("rst_ready", s_ready, 1'b1);
    chk("rst_busy", s_busy, 1'b0);
    chk("rst_resv", s_resv, 1'b0);
    chk("rst_mlt", s_mlt, 6'h00);
    chk("rst_l_ready", l_ready, 1'b1);
    chk("rst_l_mlt", l_mlt, 256'h0);
    rst = 1'b0;
    tick();

    // Basic product, with hand-derived constants as well as the model.
    accept_s(4'b1011, "b");
    finish_req(1'b0, 1'b0, "b", got);
    chk("b_const", s_mlt, 6'h2B);
    release_s("b", 6'h2B);

    accept_s(4'hF, "f");
    finish_req(1'b0, 1'b0, "f", got);
    chk("f_const", s_mlt, 6'h0F);
    release_s("f", 6'h0F);

    accept_s(4'h0, "z");
    chk("z_cleared_at_accept", s_mlt, 6'h00);
    finish_req(1'b0, 1'b0, "z", got);
    chk("z_const", s_mlt, 6'h00);
    release_s("z", 6'h00);

    // res_ready high through RUN must not clear the result early.
    s_rr = 1'b1;
    accept_s(4'h9, "rr");
    finish_req(1'b0, 1'b0, "rr", got);
    s_rr = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("rr_hold_resv", s_resv, 1'b1);
      chk("rr_hold_mlt", {250'b0, s_mlt}, got);
    end
    release_s("rr", got[5:0]);

    // Back-to-back with req_valid and res_ready held high.
    s_rr = 1'b1;
    s_rv = 1'b1;
    s_x  = 4'h5;
    sb_s.push_back(model(6, 4, 128'h3, 128'h1, 128'h5));
    tick();
    chk("bb_first_busy", s_busy, 1'b1);
    for (int k = 0; k < 3; k++) begin
      logic [3:0] nx;
      finish_req(1'b0, 1'b0, "bb", got);
      if (k < 2) begin
        nx  = 4'(k * 5 + 7);
        s_x = nx;
        sb_s.push_back(model(6, 4, 128'h3, 128'h1, {124'b0, nx}));
        tick();
        chk("bb_idle_ready", s_ready, 1'b1);
        chk("bb_idle_busy", s_busy, 1'b0);
        tick();
        chk("bb_reaccept_ready", s_ready, 1'b0);
        chk("bb_reaccept_busy", s_busy, 1'b1);
      end
    end
    s_rv = 1'b0;
    tick();
    chk("bb_end_ready", s_ready, 1'b1);
    s_rr = 1'b0;
    tick();
    chk("bb_end_busy", s_busy, 1'b0);

    // x_in changes after acceptance are ignored.
    accept_s(4'hD, "tg");
    finish_req(1'b0, 1'b1, "tg", got);
    release_s("tg", got[5:0]);

    // Reset mid-computation.
    accept_s(4'h6, "ab");
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("ab_ready", s_ready, 1'b1);
    chk("ab_busy", s_busy, 1'b0);
    chk("ab_resv", s_resv, 1'b0);
    chk("ab_mlt", s_mlt, 6'h00);
    void'(sb_s.pop_front());
    accept_s(4'b1011, "ar");
    finish_req(1'b0, 1'b0, "ar", got);
    chk("ar_const", s_mlt, 6'h2B);
    release_s("ar", 6'h2B);

    // Default-size instance with random vectors.
    for (int k = 0; k < 3; k++) begin
      lx = {$urandom, $urandom, $urandom, $urandom};
      chk("l_ready_pre", l_ready, 1'b1);
      l_x  = lx;
      l_rv = 1'b1;
      sb_l.push_back(model(256, 128, 128'h87, 128'h1, lx));
      tick();
      l_rv = 1'b0;
      l_x  = ~lx;
      finish_req(1'b1, 1'b0, "l", got);
      l_rr = 1'b1;
      tick();
      l_rr = 1'b0;
      chk("l_rel_resv", l_resv, 1'b0);
      chk("l_rel_ready", l_ready, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
